iter: RTL and testbench
=======================

// Module: iter
//
// PURPOSE
// - Synchronous wrap-around iterator: holds an index val in 0..MAX_VALUE and
//   advances it by one each clock edge on which next is high.
// - done flags the final index (val == MAX_VALUE), so a controller can step
//   through a fixed-length sequence (pixels, addresses, test vectors) and see
//   the last element.
// - Sits beside an FSM or address generator that drives next and samples val/done.
//
// PARAMETERS
// - MAX_VALUE  default 10                       last index produced; must be >= 1
// - WIDTH      default $clog2(MAX_VALUE + 1)    bit width of val; derive it, do not override
//
// PORTS
// - clk    input   1      single clock; all state updates on rising edge
// - reset  input   1      asynchronous, active-low reset (0 = reset asserted)
// - next   input   1      advance request, sampled on rising clk edge
// - val    output  WIDTH  current index, registered
// - done   output  1      high exactly while val == MAX_VALUE, registered
//
// BEHAVIOUR
// - Reset (reset == 0, asynchronous, no clock needed): val = 0, done = 0.
//   Both outputs hold while reset is low, whatever next does.
// - Reset release is synchronous in effect: the first update happens at the
//   first rising edge with reset == 1.
// - Rising edge, reset high, next == 0: val and done hold.
// - Rising edge, reset high, next == 1:
//   - val < MAX_VALUE: val <= val + 1.
//   - val == MAX_VALUE: val <= 0. This is the wrap and needs no extra cycle.
// - Latency: one cycle. The new val is visible right after the sampling edge.
//   next may stay high for back-to-back advances, one per cycle.
// - done is registered in the same always block as val:
//   - done <= (next_val == MAX_VALUE).
//   - It is high for exactly the cycles in which val == MAX_VALUE. It is never
//     out of step with val and never glitches.
// - Arithmetic: compare against MAX_VALUE before incrementing. val never takes
//   values above MAX_VALUE, even when MAX_VALUE + 1 is a power of two.
// - Reset mid-sequence: any val, including MAX_VALUE with done high, returns
//   immediately to val = 0, done = 0.
// - There is no error or overflow output. Repeated wraps are legal without limit.
// - Elaboration check: MAX_VALUE < 1 raises a fatal error or $error.
//
// STRUCTURE
// - Flat module: one sequential always block for val/done and one
//   combinational next-value block.
// - No shared package is needed. WIDTH is derived locally by the same
//   $clog2(MAX_VALUE + 1) formula that instantiating logic uses, so widths agree.
// - No sub-modules.
// - Optional assertions in an `ifdef FORMAL block:
//   - val <= MAX_VALUE at all times.
//   - done == (val == MAX_VALUE) at all times.
//
// TESTING
// All scenarios use MAX_VALUE = 10 (WIDTH = 4).
// 1. Reset: hold reset = 0 for 1 cycle, release, wait 1 edge
//    -> val = 0, done = 0.
// 2. Hold: next = 0 for 5 edges -> val stays 0, done stays 0.
// 3. Single steps: 10 pulses of next = 1 (1 cycle each, separated by next = 0)
//    -> val = 1..10 in order; done = 0 for val 1..9, done = 1 at val = 10.
// 4. Wrap: with val = 10, one next pulse -> val = 0, done = 0; one more pulse
//    -> val = 1, done = 0.
// 5. Back-to-back: next held high for 12 edges from val = 0
//    -> sequence 1..10, 0, 1; done high only on the edge where val = 10.
// 6. Async reset mid-run: at val = 7, then again at val = 10 with done = 1,
//    drive reset low between clock edges -> val = 0, done = 0 immediately,
//    no clock edge needed; counting resumes from 0 after release.

Source files
------------

// File: rtl/iter.sv
// iter -- synchronous wrap-around iterator.
//
// Holds an index in 0..MAX_VALUE and advances it by one on every rising clock
// edge where next is high, wrapping from MAX_VALUE back to 0 with no extra
// cycle. done is high exactly while the index equals MAX_VALUE.
//
// Ports:
//   clk    in   1      single clock, all updates on the rising edge
//   reset  in   1      asynchronous, active-low reset (0 = reset asserted)
//   next   in   1      advance request, sampled on the rising edge
//   val    out  WIDTH  current index, registered
//   done   out  1      high while val == MAX_VALUE, registered
module iter #(
  parameter int MAX_VALUE = 10,
  parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  output logic [WIDTH-1:0] val,
  output logic             done
);

  if (MAX_VALUE < 1) begin : g_param_check
    $fatal(1, "iter: MAX_VALUE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;
  logic             done_q;

  // Compare before incrementing so the index can never pass MAX_VALUE, even
  // when MAX_VALUE + 1 is a power of two.
  always_comb begin
    val_d = val_q;
    if (next) begin
      if (val_q == MaxV) val_d = '0;
      else               val_d = val_q + WIDTH'(1);
    end
  end

  // done is registered from the next index in the same block as val, so the
  // two outputs always change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q  <= '0;
      done_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      done_q <= (val_d == MaxV);
    end
  end

  assign val  = val_q;
  assign done = done_q;

`ifdef FORMAL
  always_comb begin
    assert (val_q <= MaxV);
    assert (done_q == (val_q == MaxV));
  end
`endif

endmodule

// File: tb/tb_iter.sv
module tb_iter;

  localparam int MAXV = 10;
  localparam int W    = $clog2(MAXV + 1);

  logic         clk;
  logic         reset;
  logic         next;
  logic [W-1:0] val;
  logic         done;

  int n_checks;
  int n_fail;

  iter #(.MAX_VALUE(MAXV)) dut (
    .clk   (clk),
    .reset (reset),
    .next  (next),
    .val   (val),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic nxt;
    int   exp_val;
    logic exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int got_val, input logic got_done,
                     input int exp_val, input logic exp_done);
    n_checks++;
    if (got_val !== exp_val || got_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s: got val=%0d done=%0b, required val=%0d done=%0b",
               name, got_val, got_done, exp_val, exp_done);
    end
  endtask

  // Drive next on the falling edge, then sample just after the rising edge.
  task automatic step(input logic n);
    @(negedge clk);
    next = n;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset(input string name);
    #2;
    reset = 1'b0;
    #1;
    chk(name, int'(val), done, 0, 1'b0);
    @(negedge clk);
    next  = 1'b0;
    reset = 1'b1;
  endtask

  int m;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    next     = 1'b0;

    // Reset state, including an edge with next high while reset is low.
    #1;
    chk("reset_async", int'(val), done, 0, 1'b0);
    @(negedge clk);
    next = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_hold", int'(val), done, 0, 1'b0);
    @(negedge clk);
    next  = 1'b0;
    reset = 1'b1;
    step(1'b0);
    chk("reset_release", int'(val), done, 0, 1'b0);

    // Table: holds, single-step pulses up to MAXV, then the wrap.
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 0, 1'b0});
    for (int k = 1; k <= MAXV; k++) begin
      vecs.push_back('{1'b1, k, logic'(k == MAXV)});
      vecs.push_back('{1'b0, k, logic'(k == MAXV)});
    end
    vecs.push_back('{1'b1, 0, 1'b0});
    vecs.push_back('{1'b0, 0, 1'b0});
    vecs.push_back('{1'b1, 1, 1'b0});
    vecs.push_back('{1'b0, 1, 1'b0});
    foreach (vecs[i]) begin
      step(vecs[i].nxt);
      chk($sformatf("vec%0d", i), int'(val), done, vecs[i].exp_val, vecs[i].exp_done);
    end

    // Back-to-back: next held for 12 edges from 0 -> 1..10, 0, 1.
    async_reset("reset_before_b2b");
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      chk($sformatf("b2b%0d", k), int'(val), done, k % (MAXV + 1), logic'(k == MAXV));
    end
    step(1'b0);
    chk("b2b_hold", int'(val), done, 1, 1'b0);

    // Async reset at val = 7.
    async_reset("reset_before_mid");
    for (int k = 1; k <= 7; k++) step(1'b1);
    chk("mid_at7", int'(val), done, 7, 1'b0);
    async_reset("reset_at7");
    step(1'b1);
    chk("resume_after7", int'(val), done, 1, 1'b0);

    // Async reset at val = MAXV with done high.
    for (int k = 2; k <= MAXV; k++) step(1'b1);
    step(1'b0);
    chk("mid_atmax", int'(val), done, MAXV, 1'b1);
    async_reset("reset_atmax");
    step(1'b1);
    chk("resume_aftermax", int'(val), done, 1, 1'b0);

    // Random next/reset against a modulo-count model.
    m = 1;
    for (int i = 0; i < 400; i++) begin
      logic n, r;
      n = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 31) != 0);
      @(negedge clk);
      next  = n;
      reset = r;
      @(posedge clk);
      #1;
      if (!r)      m = 0;
      else if (n)  m = (m + 1) % (MAXV + 1);
      chk($sformatf("rand%0d", i), int'(val), done, m, logic'(m == MAXV));
    end
    @(negedge clk);
    reset = 1'b1;
    next  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
